// File: rtl/divisor_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } state_e;

  // Width of the bit counter that walks the dividend from M-1 down to 0.
  function automatic int cnt_width(input int m);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/divisor_secuencial_paso.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract B.
module paso_division #(
  parameter int M = 4
) (
  input  logic [M-1:0] rem_i,
  input  logic         bit_i,
  input  logic [M-1:0] div_i,
  output logic [M-1:0] rem_o,
  output logic         q_o
);

  logic [M:0]   p;
  logic [M+1:0] sum;
  logic         unused_bits;

  // The carry out of p + ~B + 1 is the no-borrow flag: set when p >= B.
  assign p     = {rem_i, bit_i};
  assign sum   = {1'b0, p} + {1'b0, ~{1'b0, div_i}} + (M+2)'(1);
  assign q_o   = sum[M+1];
  assign rem_o = q_o ? sum[M-1:0] : p[M-1:0];

  // A restored remainder is always below B, so the top bits never carry information.
  assign unused_bits = ^{sum[M], p[M]};

endmodule

// File: rtl/divisor_secuencial.sv
// Iterative restoring divider with start/busy/done handshake.
// Define DIVISOR_SIGNED_EN for two's-complement operands (adds a FIX state).
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] Q,
  output logic [M-1:0] R,
  output logic         DZ,
  output logic         Z
);

  localparam int           CW  = cnt_width(M);
  localparam logic [M-1:0] ONE = M'(1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   dvd_q, dvd_d;
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M-1:0]   rem_q, rem_d;
  logic [M-1:0]   quot_q, quot_d;
  logic [M-1:0]   q_q, q_d;
  logic [M-1:0]   r_q, r_d;
  logic           dz_q, dz_d;
  logic           z_q, z_d;

  logic [M-1:0]   step_rem;
  logic           step_q;
  logic [M-1:0]   quot_next;

`ifdef DIVISOR_SIGNED_EN
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic [M-1:0]   q_fix;
  logic [M-1:0]   r_fix;

  assign q_fix = (sa_q ^ sb_q) ? (~quot_q + ONE) : quot_q;
  assign r_fix = sa_q ? (~rem_q + ONE) : rem_q;
`endif

  paso_division #(.M(M)) u_paso (
    .rem_i (rem_q),
    .bit_i (dvd_q[cnt_q]),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign quot_next = {quot_q[M-2:0], step_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    z_d     = z_q;
`ifdef DIVISOR_SIGNED_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DIVISOR_SIGNED_EN
          sa_d  = A[M-1];
          sb_d  = B[M-1];
          dvd_d = A[M-1] ? (~A + ONE) : A;
          dvs_d = B[M-1] ? (~B + ONE) : B;
`else
          dvd_d = A;
          dvs_d = B;
`endif
          rem_d  = '0;
          quot_d = '0;
          cnt_d  = CW'(M - 1);
          dz_d   = 1'b0;
          if (B == '0) begin
            // Divide by zero short-circuits straight to DONE with a saturated quotient.
            q_d     = '1;
            r_d     = A;
            dz_d    = 1'b1;
            z_d     = 1'b0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d  = step_rem;
        quot_d = quot_next;
        if (cnt_q == '0) begin
`ifdef DIVISOR_SIGNED_EN
          state_d = FIX;
`else
          q_d     = quot_next;
          r_d     = step_rem;
          z_d     = (quot_next == '0);
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

`ifdef DIVISOR_SIGNED_EN
      FIX: begin
        q_d     = q_fix;
        r_d     = r_fix;
        z_d     = (q_fix == '0);
        state_d = DONE;
      end
`endif

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      z_q     <= 1'b1;
`ifdef DIVISOR_SIGNED_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      z_q     <= z_d;
`ifdef DIVISOR_SIGNED_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`endif
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: directed cases, handshake timing and a full operand sweep.
module tb_divisor_secuencial;

  localparam int M = 4;
`ifdef DIVISOR_SIGNED_EN
  localparam int LAT = M + 2;
`else
  localparam int LAT = M + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [M-1:0] A = '0;
  logic [M-1:0] B = '0;
  logic         busy, done, DZ, Z;
  logic [M-1:0] Q, R;

  int checks = 0;
  int errors = 0;

  divisor_secuencial #(.M(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .DZ    (DZ),
    .Z     (Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: plain integer division on the (optionally signed) operand values.
  function automatic void model(input logic [M-1:0] a, input logic [M-1:0] b,
                                output logic [M-1:0] q, output logic [M-1:0] r,
                                output logic dz);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
`ifdef DIVISOR_SIGNED_EN
    if (a[M-1]) ai = ai - (1 << M);
    if (b[M-1]) bi = bi - (1 << M);
`endif
    if (bi == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      q  = M'(ai / bi);
      r  = M'(ai % bi);
      dz = 1'b0;
    end
  endfunction

  // Called in an IDLE cycle (#1 after an edge); returns in the IDLE cycle after done.
  task automatic run_div(input logic [M-1:0] a, input logic [M-1:0] b,
                         input bit disturb, input bit timing);
    logic [M-1:0] eq, er;
    logic         edz;
    int           lat;
    model(a, b, eq, er, edz);
    lat = (b == '0) ? 1 : LAT;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (timing) begin
        check("busy_cycle", 32'(busy), 32'(c < lat));
        check("done_cycle", 32'(done), 32'(c == lat));
      end
      if (disturb && c == 2) begin
        start = 1'b1;
        A = ~a;
        B = M'($urandom);
      end
      if (c < lat) begin
        @(posedge clk);
        #1;
      end
    end
    check("done_seen", 32'(done), 32'd1);
    check("Q", 32'(Q), 32'(eq));
    check("R", 32'(R), 32'(er));
    check("DZ", 32'(DZ), 32'(edz));
    check("Z", 32'(Z), 32'(eq == '0));
`ifndef DIVISOR_SIGNED_EN
    if (b != '0) begin
      check("inv_sum", 32'(Q) * 32'(b) + 32'(R), 32'(a));
      check("inv_rlt", 32'(R < b), 32'd1);
    end
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    if (timing) begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("Q_hold", 32'(Q), 32'(eq));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_Q", 32'(Q), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_DZ", 32'(DZ), 32'd0);
    check("rst_Z", 32'(Z), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    run_div(4'd13, 4'd3, 1'b0, 1'b1);
    run_div(4'd5, 4'd7, 1'b0, 1'b1);
    run_div(4'd9, 4'd0, 1'b0, 1'b1);
    run_div(4'd15, 4'd1, 1'b1, 1'b1);
    run_div(4'd6, 4'd2, 1'b0, 1'b1);
`ifdef DIVISOR_SIGNED_EN
    run_div(4'b1001, 4'd2, 1'b0, 1'b1);
    run_div(4'b1000, 4'b1111, 1'b0, 1'b1);
`endif

    // Reset in the middle of a calculation
    A = 4'd13;
    B = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_Q", 32'(Q), 32'd0);
    check("mid_rst_R", 32'(R), 32'd0);
    check("mid_rst_Z", 32'(Z), 32'd1);
    for (int c = 0; c < M + 3; c++) begin
      @(posedge clk);
      #1;
      check("no_done_after_rst", 32'(done), 32'd0);
    end

    // Full operand sweep
    for (int a = 0; a < (1 << M); a++)
      for (int b = 0; b < (1 << M); b++)
        run_div(M'(a), M'(b), 1'b0, 1'b0);

    // Random operands with full handshake checking
    for (int i = 0; i < 20; i++)
      run_div(M'($urandom), M'($urandom_range(1, (1 << M) - 1)), 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
